// File: rtl/video_rect_fill_if.sv
// Avalon-MM frame buffer port: one pixel per word.
// master: the fill engine; slave: the VGA controller's frame buffer port.
interface video_rect_fill_if #(
  parameter int AVN_AW = 19,
  parameter int AVN_DW = 16
);
  logic                  write;
  logic                  read;
  logic [AVN_AW-1:0]     address;
  logic [AVN_DW-1:0]     writedata;
  logic [AVN_DW/8-1:0]   byteenable;
  logic                  waitrequest;

  modport master (
    output write,
    output read,
    output address,
    output writedata,
    output byteenable,
    input  waitrequest
  );

  modport slave (
    input  write,
    input  read,
    input  address,
    input  writedata,
    input  byteenable,
    output waitrequest
  );
endinterface

// File: rtl/video_rect_fill.sv
// Solid rectangle fill engine for the frame buffer.
// Writes a single colour into an inclusive, axis-aligned rectangle in raster
// order, one pixel per Avalon word, address = y*H_RES + x.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for start; coordinates and colour latched (clamped)
//   S_SETUP | one cycle: reject empty rectangle or compute first row base
//   S_WRITE | issuing write beats; advances on write & !waitrequest
//   S_DONE  | one-cycle done pulse, then back to idle
module video_rect_fill #(
  parameter  int AVN_AW = 19,
  parameter  int AVN_DW = 16,
  parameter  int H_RES  = 640,
  parameter  int V_RES  = 480,
  localparam int X_W    = $clog2(H_RES),
  localparam int Y_W    = $clog2(V_RES)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [X_W-1:0]    x0,
  input  logic [X_W-1:0]    x1,
  input  logic [Y_W-1:0]    y0,
  input  logic [Y_W-1:0]    y1,
  input  logic [AVN_DW-1:0] color,
  output logic              busy,
  output logic              done,
  video_rect_fill_if.master avn
);

  localparam logic [X_W-1:0]    X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_MAX = Y_W'(V_RES - 1);
  localparam logic [AVN_AW-1:0] PITCH = AVN_AW'(H_RES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;

  // Latched command, already clamped to the visible frame.
  logic [X_W-1:0]      r_x0;
  logic [X_W-1:0]      r_x1;
  logic [Y_W-1:0]      r_y0;
  logic [Y_W-1:0]      r_y1;

  // Walk position and the word address of the start of the current row.
  logic [X_W-1:0]      r_cx;
  logic [Y_W-1:0]      r_cy;
  logic [AVN_AW-1:0]   r_row_base;

  // Registered outputs.
  logic                r_busy;
  logic                r_done;
  logic                r_write;
  logic [AVN_AW-1:0]   r_address;
  logic [AVN_DW-1:0]   r_writedata;

  logic [X_W-1:0]      w_x0_clamp;
  logic [X_W-1:0]      w_x1_clamp;
  logic [Y_W-1:0]      w_y0_clamp;
  logic [Y_W-1:0]      w_y1_clamp;
  logic                w_empty;
  logic                w_accept;
  logic [AVN_AW-1:0]   w_setup_base;
  logic [AVN_AW-1:0]   w_next_base;
  logic [X_W-1:0]      w_cx_inc;
  logic [Y_W-1:0]      w_cy_inc;
  logic                w_more_cols;
  logic                w_more_rows;

  assign w_x0_clamp   = (x0 > X_MAX) ? X_MAX : x0;
  assign w_x1_clamp   = (x1 > X_MAX) ? X_MAX : x1;
  assign w_y0_clamp   = (y0 > Y_MAX) ? Y_MAX : y0;
  assign w_y1_clamp   = (y1 > Y_MAX) ? Y_MAX : y1;

  assign w_empty      = (r_x0 > r_x1) || (r_y0 > r_y1);

  // Beat handshake; only registered state feeds the outputs, so waitrequest
  // reaches them one edge later at the earliest.
  assign w_accept     = r_write & ~avn.waitrequest;

  // The only multiplier: first row base, used once per command in SETUP.
  // Later rows step the base by one pitch.
  assign w_setup_base = AVN_AW'(r_y0) * PITCH;
  assign w_next_base  = r_row_base + PITCH;

  assign w_cx_inc     = r_cx + X_W'(1);
  assign w_cy_inc     = r_cy + Y_W'(1);
  assign w_more_cols  = (r_cx < r_x1);
  assign w_more_rows  = (r_cy < r_y1);

  // Command sequencer: latches the command, walks the rectangle in raster order
  // and owns every registered output.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_x0        <= '0;
      r_x1        <= '0;
      r_y0        <= '0;
      r_y1        <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_row_base  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_write     <= 1'b0;
      r_address   <= '0;
      r_writedata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x0        <= w_x0_clamp;
            r_x1        <= w_x1_clamp;
            r_y0        <= w_y0_clamp;
            r_y1        <= w_y1_clamp;
            r_writedata <= color;
            r_busy      <= 1'b1;
            r_state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (w_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_row_base <= w_setup_base;
            r_cx       <= r_x0;
            r_cy       <= r_y0;
            r_write    <= 1'b1;
            r_address  <= w_setup_base + AVN_AW'(r_x0);
            r_state    <= S_WRITE;
          end
        end

        S_WRITE: begin
          // Address is precomputed for the next beat so it is registered
          // and held steady through any stall.
          if (w_accept) begin
            if (w_more_cols) begin
              r_cx      <= w_cx_inc;
              r_address <= r_row_base + AVN_AW'(w_cx_inc);
            end else if (w_more_rows) begin
              r_cx       <= r_x0;
              r_cy       <= w_cy_inc;
              r_row_base <= w_next_base;
              r_address  <= w_next_base + AVN_AW'(r_x0);
            end else begin
              r_write <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_write <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign avn.write      = r_write;
  assign avn.read       = 1'b0;
  assign avn.address    = r_address;
  assign avn.writedata  = r_writedata;
  assign avn.byteenable = '1;

endmodule
